// File: rtl/dlfloat16_div_wb.sv
// Writeback/flag stage behind the combinational DLFloat16 divider: derives {nv,dz,inf,zr},
// buffers quotient+flags in a DEPTH-entry FIFO. Define DLF_DIV_WB_STICKY_EN for sticky fflags.
module dlfloat16_div_wb #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [15:0]   in_a,
    input  logic [15:0]   in_b,
    input  logic [15:0]   in_q,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [15:0]   out_q,
    output logic [3:0]    out_flags,
    output logic [CW-1:0] count
`ifdef DLF_DIV_WB_STICKY_EN
    ,
    output logic [3:0]    fflags,
    input  logic          flags_clr
`endif
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [19:0]   mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [3:0]    flags_p0;
    logic [19:0]   head;
    logic          push;
    logic          pop;
    logic          unused_sign;

    // Sign bits never affect the flags; all classification is on magnitude.
    function automatic logic [3:0] div_flags(input logic [14:0] a_mag,
                                             input logic [14:0] b_mag,
                                             input logic [14:0] q_mag);
        logic nv, dz, inf, zr;
        nv  = (q_mag == 15'h7FFF);
        dz  = (b_mag == 15'h0000) && (a_mag != 15'h0000) && (a_mag != 15'h7E00);
        inf = (q_mag == 15'h7E00);
        zr  = (q_mag == 15'h0000);
        return {nv, dz, inf, zr};
    endfunction

    assign unused_sign = ^{in_a[15], in_b[15]};
    assign flags_p0    = div_flags(in_a[14:0], in_b[14:0], in_q[14:0]);

    assign in_ready  = (count != FULL);
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign head      = mem[rptr];
    assign out_q     = out_valid ? head[19:4] : 16'h0000;
    assign out_flags = out_valid ? head[3:0]  : 4'h0;

    // Storage: data path only, never reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= {in_q, flags_p0};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

`ifdef DLF_DIV_WB_STICKY_EN
    // Clear and push in the same cycle leaves exactly the pushed flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            fflags <= 4'h0;
        end else if (push) begin
            fflags <= (flags_clr ? 4'h0 : fflags) | flags_p0;
        end else if (flags_clr) begin
            fflags <= 4'h0;
        end
    end
`endif

endmodule

// File: tb/tb_dlfloat16_div_wb.sv
// Directed bench for dlfloat16_div_wb (DEPTH=4); sticky checks compile with DLF_DIV_WB_STICKY_EN.
module tb_dlfloat16_div_wb;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic [15:0] in_q;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_q;
    logic [3:0]  out_flags;
    logic [2:0]  count;
`ifdef DLF_DIV_WB_STICKY_EN
    logic [3:0]  fflags;
    logic        flags_clr;
`endif

    int n_cmp;
    int n_err;

    dlfloat16_div_wb #(.DEPTH(4), .CW(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_q      (in_q),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_q     (out_q),
        .out_flags (out_flags),
        .count     (count)
`ifdef DLF_DIV_WB_STICKY_EN
        ,
        .fflags    (fflags),
        .flags_clr (flags_clr)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Push one vector into an empty FIFO, check the head, then pop it.
    task automatic push_pop(input string tag, input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] q, input logic [3:0] exp_flags);
        in_valid = 1'b1; in_a = a; in_b = b; in_q = q;
        step();
        in_valid = 1'b0;
        check({tag, "_q"}, 32'(out_q), 32'(q));
        check({tag, "_flags"}, 32'(out_flags), 32'(exp_flags));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, "_cnt"}, 32'(count), 32'd0);
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0; in_q = '0;
`ifdef DLF_DIV_WB_STICKY_EN
        flags_clr = 1'b0;
`endif
        step(); step();
        rst = 1'b0;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_q", 32'(out_q), 32'd0);
        check("rst_out_flags", 32'(out_flags), 32'd0);
        check("rst_count", 32'(count), 32'd0);

        // Single push, then pop
        in_valid = 1'b1; in_a = 16'h3E00; in_b = 16'h3E00; in_q = 16'h3E00;
        step();
        in_valid = 1'b0;
        check("one_valid", 32'(out_valid), 32'd1);
        check("one_q", 32'(out_q), 32'h3E00);
        check("one_flags", 32'(out_flags), 32'h0);
        check("one_count", 32'(count), 32'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("one_pop_count", 32'(count), 32'd0);
        check("one_pop_q", 32'(out_q), 32'h0000);
        check("one_pop_valid", 32'(out_valid), 32'd0);

        // Flag derivation
        push_pop("dz_inf", 16'h3E00, 16'h0000, 16'h7E00, 4'b0110);
        push_pop("nv",     16'h0000, 16'h8000, 16'hFFFF, 4'b1000);
        push_pop("zr",     16'h0000, 16'h3E00, 16'h0000, 4'b0001);
        push_pop("inf_a",  16'hFE00, 16'h0000, 16'hFE00, 4'b0010);

        // Fill past capacity with the consumer stalled
        in_a = 16'h3C00; in_b = 16'h3C00;
        for (int i = 1; i <= 5; i++) begin
            in_valid = 1'b1;
            in_q = 16'(i * 16'h1111);
            step();
            check("fill_count", 32'(count), (i < 4) ? 32'(i) : 32'd4);
        end
        in_valid = 1'b0;
        check("fill_in_ready", 32'(in_ready), 32'd0);
        check("fill_hold_q", 32'(out_q), 32'h1111);
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check("drain_q", 32'(out_q), 32'(i * 16'h1111));
            step();
        end
        out_ready = 1'b0;
        check("drain_count", 32'(count), 32'd0);
        check("drain_valid", 32'(out_valid), 32'd0);

        // Steady state at count=2 across pointer wrap
        in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_q = 16'(16'h0100 + i);
            step();
        end
        check("steady_fill", 32'(count), 32'd2);
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            in_q = 16'(16'h0102 + k);
            check("steady_q", 32'(out_q), 32'(16'h0100 + k));
            step();
            check("steady_count", 32'(count), 32'd2);
        end
        check("steady_last_q", 32'(out_q), 32'h010A);
        rst = 1'b1;
        step();
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        check("midrst_count", 32'(count), 32'd0);
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_q", 32'(out_q), 32'd0);

`ifdef DLF_DIV_WB_STICKY_EN
        check("sticky_rst", 32'(fflags), 32'd0);
        in_valid = 1'b1; in_a = 16'h3E00; in_b = 16'h0000; in_q = 16'h7E00;
        step();
        check("sticky_dz", 32'(fflags), 32'b0110);
        in_a = 16'h0000; in_b = 16'h8000; in_q = 16'hFFFF;
        step();
        check("sticky_acc", 32'(fflags), 32'b1110);
        flags_clr = 1'b1; in_a = 16'h0000; in_b = 16'h3E00; in_q = 16'h0000;
        step();
        check("sticky_clr_push", 32'(fflags), 32'b0001);
        in_valid = 1'b0;
        step();
        flags_clr = 1'b0;
        check("sticky_clr_only", 32'(fflags), 32'b0000);
        check("sticky_count", 32'(count), 32'd3);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
